// File: rtl/video_frame_tx_if.sv
// Pixel-stream handshake bundle for video_frame_tx.
// master is the transmitter view, slave the source/sink environment view.
interface video_frame_tx_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_pixel;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_pixel;
   logic              out_sof;
   logic              out_eol;
   logic              out_eof;

   modport master (
      input  in_valid,
      input  in_pixel,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_pixel,
      output out_sof,
      output out_eol,
      output out_eof
   );

   modport slave (
      output in_valid,
      output in_pixel,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_pixel,
      input  out_sof,
      input  out_eol,
      input  out_eof
   );
endinterface

// File: rtl/video_frame_tx.sv
// Frames a raw pixel stream into one HxW image per start pulse,
// tagging sof/eol/eof and buffering through a small output FIFO.
module video_frame_tx #(
   parameter int DATA_W     = 8,
   parameter int DIM_W      = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DIM_W-1:0] img_height,
   input  logic [DIM_W-1:0] img_width,
   video_frame_tx_if.master vif,
   output logic             busy,
   output logic             done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = DATA_W + 3;
   localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [DIM_W-1:0] h_q;
   logic [DIM_W-1:0] w_q;
   logic [DIM_W-1:0] row_q;
   logic [DIM_W-1:0] col_q;
   logic             zero_q;

   logic [WW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic [WW-1:0] head;
   logic [WW-1:0] wr_word;

   logic dims_ok;
   logic go;
   logic push;
   logic pop;
   logic last_col;
   logic last_row;
   logic f_sof;
   logic f_eol;
   logic f_eof;

   assign dims_ok = (img_height != '0) && (img_width != '0);
   assign go      = (state_q == IDLE) && start;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // in_ready looks only at registered state, never at in_valid
   assign vif.in_ready = (state_q == RUN) && !full;
   assign push = vif.in_valid && vif.in_ready;

   assign vif.out_valid = !empty;
   assign pop = vif.out_valid && vif.out_ready;

   assign vif.out_pixel = empty ? '0 : head[DATA_W-1:0];
   assign vif.out_sof   = !empty && head[DATA_W];
   assign vif.out_eol   = !empty && head[DATA_W+1];
   assign vif.out_eof   = !empty && head[DATA_W+2];

   assign last_col = (col_q == w_q - DIM_ONE);
   assign last_row = (row_q == h_q - DIM_ONE);
   assign f_sof    = (row_q == '0) && (col_q == '0);
   assign f_eol    = last_col;
   assign f_eof    = last_col && last_row;
   assign wr_word  = {f_eof, f_eol, f_sof, vif.in_pixel};

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = dims_ok ? RUN : DONE;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (push && f_eof) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (pop && head[DATA_W+2]) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // empty frames report busy alongside their done pulse
            busy    = zero_q;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         h_q     <= '0;
         w_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (go) begin
            zero_q <= !dims_ok;
            row_q  <= '0;
            col_q  <= '0;
            if (dims_ok) begin
               h_q <= img_height;
               w_q <= img_width;
            end
         end else if (push) begin
            if (last_col) begin
               col_q <= '0;
               if (!last_row) begin
                  row_q <= row_q + DIM_ONE;
               end
            end else begin
               col_q <= col_q + DIM_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= wr_word;
      end
   end

endmodule

// File: tb/tb_video_frame_tx.sv
// Directed bench for video_frame_tx with an output scoreboard
// built from hand-derived flag positions.
module tb_video_frame_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] img_height;
   logic [11:0] img_width;
   logic        busy;
   logic        done;

   video_frame_tx_if #(.DATA_W(8)) vif ();

   video_frame_tx #(
      .DATA_W(8),
      .DIM_W(12),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .img_height(img_height),
      .img_width(img_width),
      .vif(vif),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_done = 0;
   int n_beats = 0;
   int idx = 0;
   int tot = 0;
   int base = 0;

   logic [10:0] exp_q[$];
   logic        stall_q = 1'b0;
   logic [10:0] hold_q = '0;
   logic [10:0] word;

   assign word = {vif.out_eof, vif.out_eol,
                  vif.out_sof, vif.out_pixel};

   task automatic check(string tag, logic [31:0] obs,
                        logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) check("hold", word, hold_q);
         if (vif.out_valid && vif.out_ready) begin
            n_beats++;
            if (exp_q.size() == 0)
               check("extra_beat", exp_q.size(), 1);
            else
               check("beat", word, exp_q.pop_front());
         end
         if (!vif.out_valid) check("idle_zero", word, 0);
         stall_q = vif.out_valid && !vif.out_ready;
         hold_q  = word;
         if (done) n_done++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      vif.in_valid = (idx < tot);
      vif.in_pixel = 8'(base + idx);
      if (vif.in_valid && vif.in_ready) idx++;
      tick();
   endtask

   task automatic exp_frame(int h, int w, int b);
      for (int i = 0; i < h * w; i++) begin
         exp_q.push_back({(i == h * w - 1),
                          ((i % w) == w - 1),
                          (i == 0), 8'(b + i)});
      end
   endtask

   task automatic do_start(int h, int w);
      start      = 1'b1;
      img_height = 12'(h);
      img_width  = 12'(w);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(int max, string tag);
      logic got;
      got = 1'b0;
      for (int k = 0; k < max; k++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         step();
      end
      check(tag, got, 1);
      vif.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1);
   end

   int d0;
   int b0;

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      img_height    = '0;
      img_width     = '0;
      vif.in_valid  = 1'b0;
      vif.in_pixel  = '0;
      vif.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_in_ready", vif.in_ready, 0);
      check("rst_out_valid", vif.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // 2x3 frame, free-flowing
      base = 'h10;
      tot  = 6;
      idx  = 0;
      exp_frame(2, 3, 'h10);
      vif.out_ready = 1'b1;
      do_start(2, 3);
      check("t1_busy", busy, 1);
      check("t1_in_ready", vif.in_ready, 1);
      check("t1_no_out", vif.out_valid, 0);
      step();
      check("t1_lat_valid", vif.out_valid, 1);
      check("t1_lat_pixel", vif.out_pixel, 'h10);
      check("t1_lat_sof", vif.out_sof, 1);
      repeat (5) step();
      check("t1_accepted", idx, 6);
      check("t1_drain_rdy", vif.in_ready, 0);
      check("t1_last_pix", vif.out_pixel, 'h15);
      check("t1_last_eof", vif.out_eof, 1);
      d0 = n_done;
      step();
      check("t1_done", done, 1);
      check("t1_busy_fall", busy, 0);
      step();
      check("t1_done_once", done, 0);
      check("t1_done_cnt", n_done - d0, 1);
      check("t1_q_empty", exp_q.size(), 0);

      // backpressure, 1x8 with the sink stalled
      base = 'h20;
      tot  = 8;
      idx  = 0;
      exp_frame(1, 8, 'h20);
      vif.out_ready = 1'b0;
      do_start(1, 8);
      repeat (10) step();
      check("t2_accepted", idx, 4);
      check("t2_in_ready", vif.in_ready, 0);
      check("t2_valid", vif.out_valid, 1);
      check("t2_head", vif.out_pixel, 'h20);
      vif.out_ready = 1'b1;
      wait_done(40, "t2_done");
      check("t2_all", idx, 8);
      check("t2_q_empty", exp_q.size(), 0);
      step();

      // zero height
      tot = 1;
      idx = 0;
      vif.in_valid = 1'b1;
      do_start(0, 5);
      check("t3_busy", busy, 1);
      check("t3_done", done, 1);
      check("t3_in_ready", vif.in_ready, 0);
      check("t3_out_valid", vif.out_valid, 0);
      vif.in_valid = 1'b0;
      tot = 0;
      step();
      check("t3_busy_off", busy, 0);
      check("t3_done_off", done, 0);
      check("t3_idle_rdy", vif.in_ready, 0);

      // restart attempt mid-frame
      base = 'h40;
      tot  = 4;
      idx  = 0;
      exp_frame(2, 2, 'h40);
      d0 = n_done;
      do_start(2, 2);
      step();
      step();
      start      = 1'b1;
      img_height = 12'd4;
      step();
      start = 1'b0;
      wait_done(30, "t4_done");
      repeat (3) step();
      check("t4_done_cnt", n_done - d0, 1);
      check("t4_pixels", idx, 4);
      check("t4_q_empty", exp_q.size(), 0);
      check("t4_idle_busy", busy, 0);
      check("t4_idle_rdy", vif.in_ready, 0);

      // reset mid-frame
      base = 'h50;
      tot  = 6;
      idx  = 0;
      exp_frame(2, 3, 'h50);
      vif.out_ready = 1'b0;
      do_start(2, 3);
      repeat (3) step();
      check("t5_accepted", idx, 3);
      reset = 1'b1;
      tick();
      check("t5_in_ready", vif.in_ready, 0);
      check("t5_out_valid", vif.out_valid, 0);
      check("t5_out_word", word, 0);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      reset = 1'b0;
      vif.in_valid = 1'b0;
      exp_q.delete();
      d0 = n_done;
      b0 = n_beats;
      step();
      check("t5_no_done", n_done - d0, 0);
      base = 'h60;
      tot  = 2;
      idx  = 0;
      exp_frame(1, 2, 'h60);
      vif.out_ready = 1'b1;
      do_start(1, 2);
      wait_done(20, "t5_done2");
      step();
      check("t5_beats", n_beats - b0, 2);
      check("t5_q_empty", exp_q.size(), 0);

      // 1x1 frame
      base = 'hAB;
      tot  = 1;
      idx  = 0;
      exp_frame(1, 1, 'hAB);
      b0 = n_beats;
      do_start(1, 1);
      step();
      check("t6_valid", vif.out_valid, 1);
      check("t6_pixel", vif.out_pixel, 'hAB);
      check("t6_sof", vif.out_sof, 1);
      check("t6_eol", vif.out_eol, 1);
      check("t6_eof", vif.out_eof, 1);
      wait_done(10, "t6_done");
      step();
      check("t6_beats", n_beats - b0, 1);
      check("t6_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
